// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame FSM states,
// framing constants and a small index helper for round-robin pointers.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

  // Index one past idx, wrapping back to zero at n.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin picker: starting at the priority pointer,
// searches upward with wrap-around for the first active request.
module uart_rr_arb #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_valid
);

  int            cand_sum;
  logic [IW-1:0] cand_idx;

  // Walk the requesters in priority order and keep the first one found.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_sum    = 0;
    cand_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = int'(ptr) + k;
      if (cand_sum >= NREQ) begin
        cand_sum = cand_sum - NREQ;
      end
      cand_idx = IW'(cand_sum);
      if (!grant_valid && req[cand_idx]) begin
        grant_valid     = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin TX scheduler: arbitrates NREQ byte requesters onto one
// serial line and frames each granted byte as start, 8 data bits
// MSB-first and STOP_BITS stop bits, BIT_CYCLES clocks per bit.
// Arbitration happens in IDLE and on the last stop cycle, so a waiting
// requester follows the previous frame with no idle gap.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter  int NREQ       = 4,
  parameter  int BIT_CYCLES = 1,
  parameter  int STOP_BITS  = 1,
  localparam int IW         = $clog2(NREQ),
  localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1
) (
  input  logic                 clk_baud,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [8*NREQ-1:0]    data_in,
  output logic [NREQ-1:0]      ack,
  output logic [IW-1:0]        grant_id,
  output logic                 data_serial,
  output logic                 tx_done,
  output logic                 uart_state
);

  uart_state_e   state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    tx_byte;
  logic [IW-1:0] ptr;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_valid;

  logic last_bit_cycle;
  logic last_stop_cycle;
  logic arb_cycle;
  logic enter_last_stop;

  uart_rr_arb #(
    .NREQ(NREQ)
  ) u_arb (
    .req        (req),
    .ptr        (ptr),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_valid(arb_valid)
  );

  assign last_bit_cycle  = (bit_cnt == CW'(BIT_CYCLES - 1));
  assign last_stop_cycle = (state == STOP) && last_bit_cycle &&
                           (stop_idx == 1'(STOP_BITS - 1));
  assign arb_cycle       = (state == IDLE) || last_stop_cycle;

  // Look one cycle ahead: tx_done is registered, so it must be set on the
  // edge that enters the final cycle of the last stop bit.
  always_comb begin
    enter_last_stop = 1'b0;
    case (state)
      DATA: begin
        if (bit_idx == 3'd0 && last_bit_cycle && BIT_CYCLES == 1 && STOP_BITS == 1) begin
          enter_last_stop = 1'b1;
        end
      end
      STOP: begin
        if (!last_stop_cycle) begin
          if (last_bit_cycle) begin
            enter_last_stop = (BIT_CYCLES == 1) && (int'(stop_idx) == STOP_BITS - 2);
          end else begin
            enter_last_stop = (int'(bit_cnt) == BIT_CYCLES - 2) &&
                              (int'(stop_idx) == STOP_BITS - 1);
          end
        end
      end
      default: enter_last_stop = 1'b0;
    endcase
  end

  // Frame sequencer with registered line, handshake and status outputs.
  always_ff @(posedge clk_baud) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      tx_byte     <= '0;
      ptr         <= '0;
      ack         <= '0;
      grant_id    <= '0;
      data_serial <= UART_STOP_LVL;
      tx_done     <= 1'b0;
      uart_state  <= 1'b0;
    end else begin
      ack     <= '0;
      tx_done <= enter_last_stop;
      if (arb_cycle) begin
        bit_cnt  <= '0;
        stop_idx <= 1'b0;
        if (arb_valid) begin
          state       <= START;
          ack         <= arb_grant;
          grant_id    <= arb_idx;
          tx_byte     <= data_in[{arb_idx, 3'b000} +: UART_DATA_BITS];
          ptr         <= IW'(next_index(int'(arb_idx), NREQ));
          data_serial <= UART_START_LVL;
          uart_state  <= 1'b1;
        end else begin
          state       <= IDLE;
          data_serial <= UART_STOP_LVL;
          uart_state  <= 1'b0;
        end
      end else begin
        case (state)
          START: begin
            if (last_bit_cycle) begin
              state       <= DATA;
              bit_cnt     <= '0;
              bit_idx     <= 3'(UART_DATA_BITS - 1);
              data_serial <= tx_byte[UART_DATA_BITS-1];
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          DATA: begin
            if (last_bit_cycle) begin
              bit_cnt <= '0;
              if (bit_idx == 3'd0) begin
                state       <= STOP;
                stop_idx    <= 1'b0;
                data_serial <= UART_STOP_LVL;
              end else begin
                bit_idx     <= bit_idx - 3'd1;
                data_serial <= tx_byte[bit_idx-3'd1];
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          STOP: begin
            if (last_bit_cycle) begin
              bit_cnt  <= '0;
              stop_idx <= stop_idx + 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          default: begin
            state       <= IDLE;
            data_serial <= UART_STOP_LVL;
            uart_state  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: two instances (1 clk/bit with 1 stop bit, and
// 4 clk/bit with 2 stop bits) checked against a frame-level reference
// model plus directed scenario expectations.
module tb_uart_tx_arb;

  logic        clk_baud = 1'b0;
  logic        reset_n  = 1'b0;
  logic [3:0]  req_v   [2];
  logic [31:0] data_v  [2];
  logic [3:0]  ack_o   [2];
  logic [1:0]  gid_o   [2];
  logic        line_o  [2];
  logic        done_o  [2];
  logic        state_o [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what each instance should show in the current cycle.
  bit         m_busy [2];
  int         m_t    [2];
  logic [7:0] m_byte [2];
  logic [1:0] m_gid  [2];
  logic [3:0] m_ack  [2];
  int         m_ptr  [2];

  always #5 clk_baud = ~clk_baud;

  uart_tx_arb #(.NREQ(4), .BIT_CYCLES(1), .STOP_BITS(1)) dut_fast (
    .clk_baud(clk_baud), .reset_n(reset_n), .req(req_v[0]), .data_in(data_v[0]),
    .ack(ack_o[0]), .grant_id(gid_o[0]), .data_serial(line_o[0]),
    .tx_done(done_o[0]), .uart_state(state_o[0])
  );

  uart_tx_arb #(.NREQ(4), .BIT_CYCLES(4), .STOP_BITS(2)) dut_slow (
    .clk_baud(clk_baud), .reset_n(reset_n), .req(req_v[1]), .data_in(data_v[1]),
    .ack(ack_o[1]), .grant_id(gid_o[1]), .data_serial(line_o[1]),
    .tx_done(done_o[1]), .uart_state(state_o[1])
  );

  function automatic int bc_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int sb_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int frame_len(input int k);
    return (9 + sb_of(k)) * bc_of(k);
  endfunction

  // Serial level for model frame position: start, MSB..LSB, then stop bits.
  function automatic logic exp_line(input int k);
    int idx;
    if (!m_busy[k]) return 1'b1;
    idx = m_t[k] / bc_of(k);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[k][8-idx];
    return 1'b1;
  endfunction

  function automatic logic [8:0] model_vec(input int k);
    logic done;
    done = m_busy[k] && (m_t[k] == frame_len(k) - 1);
    return {exp_line(k), done, m_busy[k], m_ack[k], m_gid[k]};
  endfunction

  function automatic logic [8:0] obs_vec(input int k);
    return {line_o[k], done_o[k], state_o[k], ack_o[k], gid_o[k]};
  endfunction

  // Model advance: arbitrate when idle or at the end of a frame.
  always @(posedge clk_baud) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_busy[k] = 1'b0;
        m_t[k]    = 0;
        m_byte[k] = 8'h00;
        m_gid[k]  = 2'd0;
        m_ack[k]  = 4'b0000;
        m_ptr[k]  = 0;
      end else if (!m_busy[k] || m_t[k] == frame_len(k) - 1) begin
        int win;
        win = -1;
        for (int j = 0; j < 4; j++) begin
          if (win < 0 && req_v[k][(m_ptr[k] + j) % 4]) win = (m_ptr[k] + j) % 4;
        end
        if (win >= 0) begin
          m_busy[k] = 1'b1;
          m_t[k]    = 0;
          m_byte[k] = data_v[k][8*win +: 8];
          m_gid[k]  = 2'(win);
          m_ack[k]  = 4'(1 << win);
          m_ptr[k]  = (win + 1) % 4;
        end else begin
          m_busy[k] = 1'b0;
          m_ack[k]  = 4'b0000;
        end
      end else begin
        m_t[k]   = m_t[k] + 1;
        m_ack[k] = 4'b0000;
      end
    end
  end

  task automatic set_byte(input int k, input int i, input logic [7:0] b);
    data_v[k][8*i +: 8] = b;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk_baud);
    reset_n = 1'b0;
    repeat (n) @(negedge clk_baud);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_baud);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_vec(k) !== 9'b1_0_0_0000_00) begin
          n_errors++;
          $display("[TB] FAIL reset_values inst=%0d c=%0d got=%b want=%b", k, c, obs_vec(k), 9'b100000000);
        end
      end
      if (c == 3) reset_n = 1'b1;
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] pat;
    pat = 10'b0101001011;
    req_v[0] = 4'b0100;
    set_byte(0, 2, 8'hA5);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_baud);
      n_checks++;
      if (obs_vec(0) !== model_vec(0)) begin
        n_errors++;
        $display("[TB] FAIL single_model c=%0d got=%b want=%b", c, obs_vec(0), model_vec(0));
      end
      if (c <= 10) begin
        n_checks++;
        if (line_o[0] !== pat[10-c]) begin
          n_errors++;
          $display("[TB] FAIL single_line c=%0d got=%b want=%b", c, line_o[0], pat[10-c]);
        end
      end
      n_checks++;
      if (done_o[0] !== (c == 10)) begin
        n_errors++;
        $display("[TB] FAIL single_tx_done c=%0d got=%b want=%b", c, done_o[0], (c == 10));
      end
      if (c == 1) begin
        n_checks++;
        if (ack_o[0] !== 4'b0100 || gid_o[0] !== 2'd2) begin
          n_errors++;
          $display("[TB] FAIL single_ack got ack=%b gid=%0d want ack=0100 gid=2", ack_o[0], gid_o[0]);
        end
        req_v[0] = 4'b0000;
      end
      if (c == 11) begin
        n_checks++;
        if (state_o[0] !== 1'b0) begin
          n_errors++;
          $display("[TB] FAIL single_idle got=%b want=0", state_o[0]);
        end
      end
    end
  endtask

  task automatic test_contention();
    int   order[$];
    int   exp_order[5];
    logic prev_done;
    exp_order = '{0, 1, 2, 3, 0};
    prev_done = 1'b0;
    do_reset(2);
    req_v[0] = 4'b1111;
    for (int i = 0; i < 4; i++) set_byte(0, i, 8'(8'h10 + i));
    for (int c = 1; c <= 51; c++) begin
      @(negedge clk_baud);
      n_checks++;
      if (obs_vec(0) !== model_vec(0)) begin
        n_errors++;
        $display("[TB] FAIL contention_model c=%0d got=%b want=%b", c, obs_vec(0), model_vec(0));
      end
      if (ack_o[0] != 4'b0000) order.push_back(int'(gid_o[0]));
      if (prev_done && c <= 50) begin
        n_checks++;
        if ({state_o[0], line_o[0]} !== 2'b10) begin
          n_errors++;
          $display("[TB] FAIL contention_b2b c=%0d got state,line=%b want=10", c, {state_o[0], line_o[0]});
        end
      end
      prev_done = done_o[0];
      if (c == 50) req_v[0] = 4'b0000;
      if (c == 51) begin
        n_checks++;
        if (state_o[0] !== 1'b0) begin
          n_errors++;
          $display("[TB] FAIL contention_idle got=%b want=0", state_o[0]);
        end
      end
    end
    n_checks++;
    if (order.size() != 5) begin
      n_errors++;
      $display("[TB] FAIL contention_count got=%0d want=5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (order[i] != exp_order[i]) begin
          n_errors++;
          $display("[TB] FAIL contention_order i=%0d got=%0d want=%0d", i, order[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_bit_period();
    logic want;
    @(negedge clk_baud);
    req_v[1] = 4'b0001;
    set_byte(1, 0, 8'h80);
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk_baud);
      n_checks++;
      if (obs_vec(1) !== model_vec(1)) begin
        n_errors++;
        $display("[TB] FAIL period_model c=%0d got=%b want=%b", c, obs_vec(1), model_vec(1));
      end
      want = (c <= 4) ? 1'b0 : (c <= 8) ? 1'b1 : (c <= 36) ? 1'b0 : 1'b1;
      n_checks++;
      if (line_o[1] !== want) begin
        n_errors++;
        $display("[TB] FAIL period_line c=%0d got=%b want=%b", c, line_o[1], want);
      end
      n_checks++;
      if (done_o[1] !== (c == 44)) begin
        n_errors++;
        $display("[TB] FAIL period_tx_done c=%0d got=%b want=%b", c, done_o[1], (c == 44));
      end
      if (c == 1) req_v[1] = 4'b0000;
      if (c == 45) begin
        n_checks++;
        if (state_o[1] !== 1'b0) begin
          n_errors++;
          $display("[TB] FAIL period_idle got=%b want=0", state_o[1]);
        end
      end
    end
  endtask

  task automatic test_withdrawal();
    @(negedge clk_baud);
    req_v[0] = 4'b0001;
    set_byte(0, 0, 8'($urandom));
    set_byte(0, 1, 8'($urandom));
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk_baud);
      n_checks++;
      if (obs_vec(0) !== model_vec(0)) begin
        n_errors++;
        $display("[TB] FAIL withdraw_model c=%0d got=%b want=%b", c, obs_vec(0), model_vec(0));
      end
      n_checks++;
      if (ack_o[0][1] !== 1'b0) begin
        n_errors++;
        $display("[TB] FAIL withdraw_ack1 c=%0d got=%b want=0", c, ack_o[0][1]);
      end
      if (c == 11) begin
        n_checks++;
        if ({state_o[0], line_o[0]} !== 2'b01) begin
          n_errors++;
          $display("[TB] FAIL withdraw_idle got state,line=%b want=01", {state_o[0], line_o[0]});
        end
      end
      if (c == 1) req_v[0] = 4'b0000;
      if (c == 4) req_v[0] = 4'b0010;
      if (c == 5) req_v[0] = 4'b0000;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'($urandom);
    @(negedge clk_baud);
    req_v[0] = 4'b1000;
    set_byte(0, 3, b);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_baud);
      n_checks++;
      if (obs_vec(0) !== model_vec(0)) begin
        n_errors++;
        $display("[TB] FAIL midreset_model c=%0d got=%b want=%b", c, obs_vec(0), model_vec(0));
      end
      if (c >= 7 && c <= 16) begin
        n_checks++;
        if (done_o[0] !== 1'b0) begin
          n_errors++;
          $display("[TB] FAIL midreset_no_done c=%0d got=%b want=0", c, done_o[0]);
        end
      end
      if (c == 1) req_v[0] = 4'b0000;
      if (c == 6) begin
        n_checks++;
        if (line_o[0] !== b[3]) begin
          n_errors++;
          $display("[TB] FAIL midreset_bit3 got=%b want=%b", line_o[0], b[3]);
        end
        reset_n = 1'b0;
      end
      if (c == 7) begin
        n_checks++;
        if ({line_o[0], state_o[0], ack_o[0]} !== 6'b1_0_0000) begin
          n_errors++;
          $display("[TB] FAIL midreset_abort got line,state,ack=%b want=100000", {line_o[0], state_o[0], ack_o[0]});
        end
        reset_n  = 1'b1;
        req_v[0] = 4'b1010;
        set_byte(0, 1, 8'($urandom));
        set_byte(0, 3, 8'($urandom));
      end
      if (c == 8) begin
        n_checks++;
        if (ack_o[0] !== 4'b0010 || gid_o[0] !== 2'd1) begin
          n_errors++;
          $display("[TB] FAIL midreset_regrant got ack=%b gid=%0d want ack=0010 gid=1", ack_o[0], gid_o[0]);
        end
        req_v[0] = 4'b0000;
      end
    end
  endtask

  task automatic test_random(input int k, input int ncycles);
    for (int c = 1; c <= ncycles + frame_len(k) + 2; c++) begin
      @(negedge clk_baud);
      n_checks++;
      if (obs_vec(k) !== model_vec(k)) begin
        n_errors++;
        $display("[TB] FAIL random_model inst=%0d c=%0d got=%b want=%b", k, c, obs_vec(k), model_vec(k));
      end
      if (c > ncycles) begin
        req_v[k] = 4'b0000;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (req_v[k][i] && ack_o[k][i]) begin
            req_v[k][i] = ($urandom_range(0, 2) == 0);
            data_v[k][8*i +: 8] = 8'($urandom);
          end else if (req_v[k][i]) begin
            if ($urandom_range(0, 29) == 0) req_v[k][i] = 1'b0;
          end else if ($urandom_range(0, 4) == 0) begin
            req_v[k][i] = 1'b1;
            data_v[k][8*i +: 8] = 8'($urandom);
          end
        end
      end
    end
    n_checks++;
    if (state_o[k] !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL random_drain inst=%0d got=%b want=0", k, state_o[k]);
    end
  endtask

  initial begin
    req_v[0]  = 4'b0000;
    req_v[1]  = 4'b0000;
    data_v[0] = 32'h0;
    data_v[1] = 32'h0;
    test_reset();
    test_single_frame();
    test_contention();
    test_bit_period();
    test_withdrawal();
    test_reset_mid_frame();
    test_random(0, 400);
    test_random(1, 400);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin transmit scheduler for the UART TX path. Shares one serial line among `NREQ` byte requesters, latches the granted byte, and frames it as start bit, 8 data bits MSB-first and stop bit(s), sequenced bit by bit with a programmable bit period. Sits between the producer blocks and the TX pin, beside `uart_tx`; its outputs keep the existing `tx_done` / `uart_state` semantics.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `BIT_CYCLES`, 1: `clk_baud` cycles per serial bit, >=1. The default gives one bit per clock.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.

Ports:
- `clk_baud` in 1: the only clock; all logic on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req` in NREQ: per-requester request; hold with its byte stable until `ack`.
- `data_in` in 8*NREQ: byte i is `data_in[8*i+7:8*i]`.
- `ack` out NREQ: one-hot, one-cycle pulse when the byte of requester i is latched.
- `grant_id` out clog2(NREQ): index of the requester whose frame is on the line; valid while `uart_state`=1.
- `data_serial` out 1: serial line, idles high.
- `tx_done` out 1: high for the final cycle of the last stop bit.
- `uart_state` out 1: high while a frame is in progress (START..STOP).

## Operation
- FSM states: IDLE, START, DATA, STOP.
- **IDLE**
  - `data_serial`=1.
  - If any `req`: pick a winner round-robin, latch its byte, go to START.
  - Else stay in IDLE.
- **START**: `data_serial`=0 for BIT_CYCLES, then go to DATA.
- **DATA**
  - 3-bit index counts 7 down to 0; `data_serial`=byte[idx].
  - Each bit lasts BIT_CYCLES; go to STOP after bit 0.
- **STOP**
  - `data_serial`=1 for STOP_BITS*BIT_CYCLES.
  - On the last cycle, assert `tx_done` and arbitrate as IDLE does.
  - If a winner exists, go directly to START with no idle gap; else go to IDLE.
- **Round-robin**
  - The priority pointer is one past the last grant; search upward with wrap-around.
  - After reset, requester 0 has highest priority.
- **Handshake**
  - `ack[i]`, `grant_id` and the byte latch are registered on the same edge that enters START.
  - A requester may drop `req` before `ack` (withdrawal); it is then not granted.
  - `req` and `data_in` are ignored outside the arbitration cycle.
- **Bit timing**: a bit-period counter of width clog2(BIT_CYCLES), wrapping at BIT_CYCLES-1, drives the bit advance.

## Timing
- Reset values: state IDLE, `data_serial`=1, `ack`=0, `tx_done`=0, `uart_state`=0, `grant_id`=0, pointer=0, counters=0.
- Reset asserted mid-frame aborts the frame. The line is high from the cycle after the reset edge, and no `tx_done` is issued for the aborted frame.
- Latency: `req` sampled high in IDLE at edge N gives `ack`, `uart_state`=1 and start bit during cycle N+1.
- Frame length is (9+STOP_BITS)*BIT_CYCLES cycles, from first start-bit cycle to `tx_done` inclusive.
- **Back-to-back frames**
  - The next `ack` and start bit appear in the cycle after `tx_done`.
  - `uart_state` stays 1 across the boundary.
  - Sustained throughput is exactly one frame per (9+STOP_BITS)*BIT_CYCLES cycles.
- Idle after a frame: `uart_state` goes 0 in the cycle after `tx_done`.
- Simultaneous requests are resolved by the pointer alone. A requester re-asserting in the same cycle as its `ack` is treated as a new request.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE/START/DATA/STOP);
  - the constants `UART_DATA_BITS`=8, `UART_START_LVL`=0 and `UART_STOP_LVL`=1.
- Sub-module `uart_rr_arb`:
  - combinational round-robin pick from `req` and the pointer;
  - outputs a one-hot grant and an index.
- The pointer register and the FSM live in `uart_tx_arb`.

## Test plan
- **Single frame**: `req[2]`=1, byte 0xA5, BIT_CYCLES=1.
  - `ack[2]` pulses for one cycle; `grant_id`=2.
  - Line reads 0,1,0,1,0,0,1,0,1,1.
  - `tx_done` is high on cycle 10; `uart_state` is 0 on cycle 11.
- **Contention**: all four `req` held high continuously, bytes 0x10..0x13.
  - Grant order is 0,1,2,3,0.
  - Frames are back-to-back, with the start bit in the cycle after each `tx_done`.
- **Bit period**: BIT_CYCLES=4, STOP_BITS=2, byte 0x80.
  - Each bit is held for 4 cycles; frame is 44 cycles.
  - The MSB-one bit is high for cycles 5..8.
- **Withdrawal**: `req[1]` pulsed for one cycle during a busy frame, then dropped.
  - No `ack[1]`; the line returns to idle after the frame.
- **Reset mid-frame**: `reset_n` low during data bit 3.
  - Line is high and `uart_state`=0 from the next cycle; no `tx_done`.
  - The next grant goes to the lowest-index requester.
